combo_lock_n: RTL and testbench
===============================

Name: combo_lock_n

Overview:
Parametrised Moore combination lock; successor to the team's fixed two-bit, two-entry locker FSM. Accepts DIGITS entries of DIGIT_W bits each, one per `enter` pulse, compared against a reprogrammable code register. Adds a bounded-retry counter with timed lockout and optional auto-relock. Sits between keypad debounce/pulse logic and the actuator/status LEDs.

Parameters:
DIGITS, 4, number of digits per code (>=2)
DIGIT_W, 4, bits per digit
DEFAULT_CODE, 16'h1234, reset code (DIGITS*DIGIT_W bits); digit k = bits [k*DIGIT_W +: DIGIT_W], k=0 entered first
MAX_TRIES, 3, consecutive failed codes before lockout (>=1)
LOCKOUT_CYCLES, 1000, lockout duration in clk cycles (>=1)
RELOCK_CYCLES, 0, auto-relock delay from OPEN in cycles; 0 disables

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
digit  in  DIGIT_W  digit value, sampled when enter=1
enter  in  1  single-cycle strobe, one digit per pulse
clear  in  1  single-cycle strobe, abandon entry / acknowledge error
lock  in  1  single-cycle strobe, relock from OPEN
code_load  in  1  load code_in as new code (honoured only in OPEN)
code_in  in  DIGITS*DIGIT_W  new code value
open  out  1  lock released
error  out  1  wrong code or lockout
lockout  out  1  lockout timer running
digit_cnt  out  $clog2(DIGITS+1)  digits entered so far in current attempt
tries_left  out  $clog2(MAX_TRIES+1)  MAX_TRIES minus consecutive failures

Behaviour:
- States: LOCKED, OPEN, ERROR, LOCKOUT. All outputs registered and decoded from state and counters only (Moore); no output depends combinationally on inputs.
- Reset (reset=0, async): state=LOCKED, code_reg=DEFAULT_CODE, digit_cnt=0, mismatch=0, fail_cnt=0, timer=0; open=0, error=0, lockout=0, tries_left=MAX_TRIES.
- LOCKED, enter=1: mismatch |= (digit != code_reg digit[digit_cnt]); digit_cnt++. No early abort: all DIGITS digits are always collected, so a wrong digit is not revealed before the end.
- LOCKED, final enter (digit_cnt==DIGITS-1):
  - Overall match -> OPEN; fail_cnt=0.
  - Otherwise fail_cnt++; next state LOCKOUT if fail_cnt+1==MAX_TRIES, else ERROR.
  - digit_cnt and mismatch both cleared.
- LOCKED, clear=1: digit_cnt=0, mismatch=0, fail_cnt unchanged. clear together with enter: clear wins and the digit is discarded.
- ERROR: error=1. enter ignored. clear -> LOCKED.
- LOCKOUT: error=1, lockout=1. Timer loads LOCKOUT_CYCLES-1 on entry and decrements each cycle. enter and clear are ignored. At timer==0 -> LOCKED, fail_cnt=0. Lockout therefore lasts exactly LOCKOUT_CYCLES cycles.
- OPEN: open=1. lock -> LOCKED. code_load loads code_in into code_reg; the new code is effective from the next attempt. code_load in any other state is ignored.
  - code_load and lock in the same cycle: both take effect.
  - If RELOCK_CYCLES>0, the timer loads on entry to OPEN and the state returns to LOCKED on expiry. lock before expiry wins.
- Latency: the final enter sampled at edge N -> open/error/lockout valid after edge N (one-cycle registered latency from the strobe).
- enter held high for several cycles counts as several digits; debouncing is upstream.
- Reset asserted mid-entry, mid-lockout, or while OPEN: immediate return to the reset values above, and code_reg reverts to DEFAULT_CODE.
- Widths: fail_cnt saturates at MAX_TRIES. The timer is $clog2(max(LOCKOUT_CYCLES,RELOCK_CYCLES)+1) bits.

Decomposition:
- Shared package combo_lock_pkg holds the state encoding localparams (LOCKED=2'b00, OPEN=2'b01, ERROR=2'b10, LOCKOUT=2'b11) and a clog2 width helper.
- One sub-module: lock_timer (loadable down-counter with load, enable and zero flag), used for both lockout and auto-relock.

Test Plan:
Parameters DIGITS=4, DIGIT_W=4, DEFAULT_CODE=16'h1234, MAX_TRIES=3, LOCKOUT_CYCLES=20, RELOCK_CYCLES=0 unless stated.
1. After reset, enter 4,3,2,1 (digit k=0 first per the code packing) -> open=1 one cycle after the 4th strobe; error=0; tries_left=3; digit_cnt=0.
2. Enter 4,3,2,0 -> error=1, open=0, tries_left=2, digit_cnt reaches 3 before the final strobe with no early error; clear -> error=0, state LOCKED.
3. Three consecutive wrong codes -> lockout=1, error=1 for exactly 20 cycles; enter and clear ignored during lockout; then LOCKED with tries_left=3.
4. Enter 4,3 then clear, then 4,3,2,1 -> open=1. Repeat with clear and enter in the same cycle mid-entry -> digit discarded, digit_cnt=0.
5. In OPEN, code_load with code_in=16'hABCD, then lock -> D,C,B,A opens; old sequence 4,3,2,1 -> error. Also: code_load in LOCKED -> no effect.
6. RELOCK_CYCLES=10: open, then no lock pulse -> open drops after 10 cycles. Separately, assert reset mid-entry and mid-lockout -> all outputs return to reset values asynchronously; code reverts to 16'h1234.

Source files
------------

// File: rtl/combo_lock_pkg.sv
// combo_lock_pkg
//   Shared definitions for the parametrised combination lock:
//   - state encoding (LOCKED/OPEN/ERROR/LOCKOUT) as a 2-bit enum
//   - width helpers used to size counters and the shared timer
package combo_lock_pkg;

  localparam logic [1:0] ST_LOCKED_ENC  = 2'b00;
  localparam logic [1:0] ST_OPEN_ENC    = 2'b01;
  localparam logic [1:0] ST_ERROR_ENC   = 2'b10;
  localparam logic [1:0] ST_LOCKOUT_ENC = 2'b11;

  typedef enum logic [1:0] {
    LOCKED  = ST_LOCKED_ENC,
    OPEN    = ST_OPEN_ENC,
    ERROR   = ST_ERROR_ENC,
    LOCKOUT = ST_LOCKOUT_ENC
  } lock_state_e;

  // Number of bits needed to hold any value in 0..n (never less than 1).
  function automatic int clog2w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lock_timer.sv
// lock_timer
//   Loadable down-counter shared by the lockout and auto-relock intervals.
//   Ports:
//     clk      - rising-edge clock
//     reset    - asynchronous active-low reset (count returns to 0)
//     load     - load load_val this cycle (has priority over en)
//     load_val - value to load
//     en       - decrement by one while non-zero
//     zero     - count is zero (decoded from the registered count)
module lock_timer #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Counting stops at zero so a lingering enable never wraps around.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/combo_lock_n.sv
// combo_lock_n
//   Parametrised Moore combination lock with bounded retries, timed lockout
//   and optional auto-relock. Digits arrive one per enter strobe, digit 0
//   (code bits [DIGIT_W-1:0]) first, and are compared against a code register
//   that can be reprogrammed while the lock is open.
//   Ports:
//     clk        - rising-edge clock
//     reset      - asynchronous active-low reset
//     digit      - digit value, sampled when enter=1
//     enter      - one digit per cycle it is high
//     clear      - abandon current entry / acknowledge an error
//     lock       - relock from OPEN
//     code_load  - load code_in as the new code (only while OPEN)
//     code_in    - new code value
//     open       - lock released
//     error      - wrong code entered or lockout in progress
//     lockout    - lockout timer running
//     digit_cnt  - digits entered so far in the current attempt
//     tries_left - MAX_TRIES minus consecutive failures
module combo_lock_n
  import combo_lock_pkg::*;
#(
  parameter int                          DIGITS         = 4,
  parameter int                          DIGIT_W        = 4,
  parameter logic [DIGITS*DIGIT_W-1:0]   DEFAULT_CODE   = 16'h1234,
  parameter int                          MAX_TRIES      = 3,
  parameter int                          LOCKOUT_CYCLES = 1000,
  parameter int                          RELOCK_CYCLES  = 0
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [DIGIT_W-1:0]               digit,
  input  logic                             enter,
  input  logic                             clear,
  input  logic                             lock,
  input  logic                             code_load,
  input  logic [DIGITS*DIGIT_W-1:0]        code_in,
  output logic                             open,
  output logic                             error,
  output logic                             lockout,
  output logic [$clog2(DIGITS+1)-1:0]      digit_cnt,
  output logic [$clog2(MAX_TRIES+1)-1:0]   tries_left
);

  localparam int CW     = $clog2(DIGITS + 1);
  localparam int FW     = $clog2(MAX_TRIES + 1);
  localparam int CODE_W = DIGITS * DIGIT_W;
  localparam int TW     = clog2w(max_int(LOCKOUT_CYCLES, RELOCK_CYCLES));

  localparam bit RELOCK_EN     = (RELOCK_CYCLES > 0);
  localparam int RELOCK_LOAD_I = RELOCK_EN ? (RELOCK_CYCLES - 1) : 0;

  // Timer holds "cycles remaining after this one", so loading N-1 yields a
  // state residency of exactly N cycles.
  localparam logic [TW-1:0] LOCK_LOAD   = TW'(LOCKOUT_CYCLES - 1);
  localparam logic [TW-1:0] RELOCK_LOAD = TW'(RELOCK_LOAD_I);

  lock_state_e         state_q,     state_d;
  logic [CW-1:0]       digit_cnt_q, digit_cnt_d;
  logic                mismatch_q,  mismatch_d;
  logic [FW-1:0]       fail_cnt_q,  fail_cnt_d;
  logic [CODE_W-1:0]   code_q,      code_d;

  logic                timer_load;
  logic [TW-1:0]       timer_val;
  logic                timer_en;
  logic                timer_zero;

  logic [DIGIT_W-1:0]  cur_digit;
  logic                mismatch_next;

  // Expected digit for the current position in the attempt.
  always_comb begin
    cur_digit = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (digit_cnt_q == CW'(k)) begin
        cur_digit = code_q[k*DIGIT_W +: DIGIT_W];
      end
    end
  end

  // Accumulated mismatch including the digit being entered now; a wrong
  // digit is only remembered, never acted on until the final digit.
  assign mismatch_next = mismatch_q | (digit != cur_digit);

  // Timer only counts in the states that own it.
  assign timer_en = (state_q == LOCKOUT) || (RELOCK_EN && (state_q == OPEN));

  lock_timer #(
    .W (TW)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (timer_load),
    .load_val (timer_val),
    .en       (timer_en),
    .zero     (timer_zero)
  );

  // Next-state and counter update.
  always_comb begin
    state_d     = state_q;
    digit_cnt_d = digit_cnt_q;
    mismatch_d  = mismatch_q;
    fail_cnt_d  = fail_cnt_q;
    code_d      = code_q;
    timer_load  = 1'b0;
    timer_val   = LOCK_LOAD;

    case (state_q)
      LOCKED: begin
        if (clear) begin
          // clear wins over a simultaneous enter; the digit is discarded
          digit_cnt_d = '0;
          mismatch_d  = 1'b0;
        end else if (enter) begin
          if (digit_cnt_q == CW'(DIGITS - 1)) begin
            digit_cnt_d = '0;
            mismatch_d  = 1'b0;
            if (!mismatch_next) begin
              state_d    = OPEN;
              fail_cnt_d = '0;
              if (RELOCK_EN) begin
                timer_load = 1'b1;
                timer_val  = RELOCK_LOAD;
              end
            end else begin
              if (fail_cnt_q != FW'(MAX_TRIES)) begin
                fail_cnt_d = fail_cnt_q + 1'b1;
              end
              if (fail_cnt_q == FW'(MAX_TRIES - 1)) begin
                state_d    = LOCKOUT;
                timer_load = 1'b1;
                timer_val  = LOCK_LOAD;
              end else begin
                state_d = ERROR;
              end
            end
          end else begin
            digit_cnt_d = digit_cnt_q + 1'b1;
            mismatch_d  = mismatch_next;
          end
        end
      end

      ERROR: begin
        if (clear) begin
          state_d = LOCKED;
        end
      end

      LOCKOUT: begin
        // Keypad is dead until the timer runs out; retries are then restored.
        if (timer_zero) begin
          state_d    = LOCKED;
          fail_cnt_d = '0;
        end
      end

      OPEN: begin
        // A code load and a relock in the same cycle both take effect.
        if (code_load) begin
          code_d = code_in;
        end
        if (lock) begin
          state_d = LOCKED;
        end else if (RELOCK_EN && timer_zero) begin
          state_d = LOCKED;
        end
      end

      default: begin
        state_d = LOCKED;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= LOCKED;
      digit_cnt_q <= '0;
      mismatch_q  <= 1'b0;
      fail_cnt_q  <= '0;
      code_q      <= DEFAULT_CODE;
    end else begin
      state_q     <= state_d;
      digit_cnt_q <= digit_cnt_d;
      mismatch_q  <= mismatch_d;
      fail_cnt_q  <= fail_cnt_d;
      code_q      <= code_d;
    end
  end

  // Moore outputs, decoded purely from registered state and counters.
  assign open       = (state_q == OPEN);
  assign error      = (state_q == ERROR) || (state_q == LOCKOUT);
  assign lockout    = (state_q == LOCKOUT);
  assign digit_cnt  = digit_cnt_q;
  assign tries_left = FW'(MAX_TRIES) - fail_cnt_q;

endmodule

// File: tb/tb_combo_lock_n.sv
// tb_combo_lock_n
//   Directed bench for combo_lock_n. Two instances share every input:
//   dut0 without auto-relock, dut1 with RELOCK_CYCLES=10. The stimulus
//   process pushes the expected outputs for a given clock edge into a
//   scoreboard queue; a monitor compares them on the following falling edge.
module tb_combo_lock_n;

  logic        clk;
  logic        reset;
  logic [3:0]  digit;
  logic        enter;
  logic        clear;
  logic        lock;
  logic        code_load;
  logic [15:0] code_in;

  logic        o0_open, o0_error, o0_lockout;
  logic [2:0]  o0_dcnt;
  logic [1:0]  o0_tries;
  logic        o1_open, o1_error, o1_lockout;
  logic [2:0]  o1_dcnt;
  logic [1:0]  o1_tries;

  combo_lock_n #(
    .DIGITS(4), .DIGIT_W(4), .DEFAULT_CODE(16'h1234),
    .MAX_TRIES(3), .LOCKOUT_CYCLES(20), .RELOCK_CYCLES(0)
  ) dut0 (
    .clk(clk), .reset(reset), .digit(digit), .enter(enter), .clear(clear),
    .lock(lock), .code_load(code_load), .code_in(code_in),
    .open(o0_open), .error(o0_error), .lockout(o0_lockout),
    .digit_cnt(o0_dcnt), .tries_left(o0_tries)
  );

  combo_lock_n #(
    .DIGITS(4), .DIGIT_W(4), .DEFAULT_CODE(16'h1234),
    .MAX_TRIES(3), .LOCKOUT_CYCLES(20), .RELOCK_CYCLES(10)
  ) dut1 (
    .clk(clk), .reset(reset), .digit(digit), .enter(enter), .clear(clear),
    .lock(lock), .code_load(code_load), .code_in(code_in),
    .open(o1_open), .error(o1_error), .lockout(o1_lockout),
    .digit_cnt(o1_dcnt), .tries_left(o1_tries)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    int   cyc;
    int   sel;
    logic o;
    logic er;
    logic lo;
    int   dc;
    int   tl;
  } exp_t;

  exp_t  sb[$];
  string nm_q[$];

  int checks = 0;
  int errors = 0;
  bit done = 1'b0;
  bit done_seen = 1'b0;

  exp_t       mon_e;
  string      mon_nm;
  logic [7:0] mon_act;
  logic [7:0] mon_exp;

  // Monitor: compare every expectation whose edge has passed.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      mon_e  = sb.pop_front();
      mon_nm = nm_q.pop_front();
      if (mon_e.sel == 0)
        mon_act = {o0_open, o0_error, o0_lockout, o0_dcnt, o0_tries};
      else
        mon_act = {o1_open, o1_error, o1_lockout, o1_dcnt, o1_tries};
      mon_exp = {mon_e.o, mon_e.er, mon_e.lo, 3'(mon_e.dc), 2'(mon_e.tl)};
      checks++;
      if (mon_e.cyc != cyc || mon_act !== mon_exp) begin
        errors++;
        $display("FAIL %s cyc=%0d dut%0d: got open=%b error=%b lockout=%b digit_cnt=%0d tries_left=%0d, want open=%b error=%b lockout=%b digit_cnt=%0d tries_left=%0d (due cyc %0d)",
                 mon_nm, cyc, mon_e.sel, mon_act[7], mon_act[6], mon_act[5],
                 mon_act[4:2], mon_act[1:0], mon_exp[7], mon_exp[6], mon_exp[5],
                 mon_exp[4:2], mon_exp[1:0], mon_e.cyc);
      end
    end
    if (done && !done_seen) begin
      done_seen = 1'b1;
      checks++;
      if (sb.size() != 0) begin
        errors++;
        $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got cyc=%0d, want finish", cyc);
    $fatal(1, "timeout");
  end

  task automatic push_exp(input int at, input int sel, input logic o, input logic er,
                          input logic lo, input int dc, input int tl, input string nm);
    exp_t x;
    x.cyc = at; x.sel = sel; x.o = o; x.er = er; x.lo = lo; x.dc = dc; x.tl = tl;
    sb.push_back(x);
    nm_q.push_back(nm);
  endtask

  // Expectation for the next rising edge, for one instance or both.
  task automatic chk(input int sel, input logic o, input logic er, input logic lo,
                     input int dc, input int tl, input string nm);
    push_exp(cyc + 1, sel, o, er, lo, dc, tl, nm);
  endtask

  task automatic chk_both(input logic o, input logic er, input logic lo,
                          input int dc, input int tl, input string nm);
    push_exp(cyc + 1, 0, o, er, lo, dc, tl, nm);
    push_exp(cyc + 1, 1, o, er, lo, dc, tl, nm);
  endtask

  // Expectation for the current cycle, used right after an async reset.
  task automatic chk_now_both(input string nm);
    push_exp(cyc, 0, 1'b0, 1'b0, 1'b0, 0, 3, nm);
    push_exp(cyc, 1, 1'b0, 1'b0, 1'b0, 0, 3, nm);
  endtask

  task automatic drive(input logic [3:0] d, input logic en, input logic cl,
                       input logic lk, input logic ld, input logic [15:0] ci);
    @(negedge clk);
    digit = d; enter = en; clear = cl; lock = lk; code_load = ld; code_in = ci;
  endtask

  task automatic idle();
    drive(4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
  endtask

  task automatic key(input logic [3:0] d);
    drive(d, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
  endtask

  task automatic clr();
    drive(4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
  endtask

  task automatic lk();
    drive(4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
  endtask

  // Enters four digits, digit 0 (bits [3:0]) first.
  task automatic enter4(input logic [15:0] c);
    key(c[3:0]); key(c[7:4]); key(c[11:8]); key(c[15:12]);
  endtask

  initial begin
    reset = 1'b0; digit = 4'h0; enter = 1'b0; clear = 1'b0;
    lock = 1'b0; code_load = 1'b0; code_in = 16'h0000;

    // Reset state
    idle();
    chk_both(1'b0, 1'b0, 1'b0, 0, 3, "reset_state");
    idle();
    reset = 1'b1;

    // 1: correct code 4,3,2,1 opens one edge after the 4th strobe
    key(4'h4); chk(0, 1'b0, 1'b0, 1'b0, 1, 3, "t1_d1");
    key(4'h3); chk(0, 1'b0, 1'b0, 1'b0, 2, 3, "t1_d2");
    key(4'h2); chk(0, 1'b0, 1'b0, 1'b0, 3, 3, "t1_d3");
    key(4'h1); chk_both(1'b1, 1'b0, 1'b0, 0, 3, "t1_open");
    lk();      chk_both(1'b0, 1'b0, 1'b0, 0, 3, "t1_lock");

    // 2: wrong final digit, no early error, clear acknowledges
    key(4'h4); chk(0, 1'b0, 1'b0, 1'b0, 1, 3, "t2_d1");
    key(4'h3); chk(0, 1'b0, 1'b0, 1'b0, 2, 3, "t2_d2");
    key(4'h2); chk(0, 1'b0, 1'b0, 1'b0, 3, 3, "t2_no_early_err");
    key(4'h0); chk(0, 1'b0, 1'b1, 1'b0, 0, 2, "t2_error");
    key(4'h5); chk(0, 1'b0, 1'b1, 1'b0, 0, 2, "t2_enter_ignored");
    clr();     chk(0, 1'b0, 1'b0, 1'b0, 0, 2, "t2_clear");

    // 3: correct code restores retries, then three wrong codes -> lockout
    enter4(16'h1234); chk_both(1'b1, 1'b0, 1'b0, 0, 3, "t3_fail_reset");
    lk();
    enter4(16'h0000); chk(0, 1'b0, 1'b1, 1'b0, 0, 2, "t3_wrong1");
    clr();
    enter4(16'h0000); chk(0, 1'b0, 1'b1, 1'b0, 0, 1, "t3_wrong2");
    clr();
    enter4(16'h0000); chk_both(1'b0, 1'b1, 1'b1, 0, 0, "t3_lockout_entry");
    for (int i = 1; i < 20; i++) begin
      if (i % 3 == 0) key(4'h4);
      else if (i % 3 == 1) clr();
      else idle();
      chk_both(1'b0, 1'b1, 1'b1, 0, 0, "t3_lockout_hold");
    end
    idle(); chk_both(1'b0, 1'b0, 1'b0, 0, 3, "t3_lockout_end");

    // 4: clear mid-entry; clear together with enter discards the digit
    key(4'h4); chk(0, 1'b0, 1'b0, 1'b0, 1, 3, "t4_d1");
    key(4'h3); chk(0, 1'b0, 1'b0, 1'b0, 2, 3, "t4_d2");
    clr();     chk(0, 1'b0, 1'b0, 1'b0, 0, 3, "t4_clear");
    enter4(16'h1234); chk(0, 1'b1, 1'b0, 1'b0, 0, 3, "t4_open_after_clear");
    lk();      chk(0, 1'b0, 1'b0, 1'b0, 0, 3, "t4_lock");
    key(4'h4);
    key(4'h3); chk(0, 1'b0, 1'b0, 1'b0, 2, 3, "t4_d2b");
    drive(4'h7, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
    chk(0, 1'b0, 1'b0, 1'b0, 0, 3, "t4_clear_wins");
    enter4(16'h1234); chk_both(1'b1, 1'b0, 1'b0, 0, 3, "t4_open2");

    // 5: reprogram in OPEN; code_load in LOCKED ignored
    drive(4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 16'hABCD);
    chk_both(1'b1, 1'b0, 1'b0, 0, 3, "t5_load_open");
    lk();      chk_both(1'b0, 1'b0, 1'b0, 0, 3, "t5_lock");
    enter4(16'hABCD); chk_both(1'b1, 1'b0, 1'b0, 0, 3, "t5_new_code");
    lk();
    enter4(16'h1234); chk(0, 1'b0, 1'b1, 1'b0, 0, 2, "t5_old_code_err");
    clr();
    drive(4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h1234);
    chk(0, 1'b0, 1'b0, 1'b0, 0, 2, "t5_load_locked");
    enter4(16'h1234); chk(0, 1'b0, 1'b1, 1'b0, 0, 1, "t5_load_ignored");
    clr();
    enter4(16'hABCD); chk_both(1'b1, 1'b0, 1'b0, 0, 3, "t5_still_abcd");
    lk();

    // 6a: auto-relock after 10 cycles on dut1 only
    enter4(16'hABCD); chk_both(1'b1, 1'b0, 1'b0, 0, 3, "t6_open");
    for (int i = 1; i < 10; i++) begin
      idle();
      chk(1, 1'b1, 1'b0, 1'b0, 0, 3, "t6_relock_hold");
      chk(0, 1'b1, 1'b0, 1'b0, 0, 3, "t6_stay_open");
    end
    idle();
    chk(1, 1'b0, 1'b0, 1'b0, 0, 3, "t6_relocked");
    chk(0, 1'b1, 1'b0, 1'b0, 0, 3, "t6_norelock");
    lk();      chk_both(1'b0, 1'b0, 1'b0, 0, 3, "t6_lock");

    // 6b: async reset mid-entry; code reverts to 1234
    key(4'hD);
    key(4'hC); chk_both(1'b0, 1'b0, 1'b0, 2, 3, "t6_pre_rst_entry");
    idle();
    @(negedge clk);
    @(posedge clk);
    #2;
    reset = 1'b0;
    chk_now_both("t6_async_rst_entry");
    idle();
    chk_both(1'b0, 1'b0, 1'b0, 0, 3, "t6_rst_held");
    reset = 1'b1;
    enter4(16'h1234); chk_both(1'b1, 1'b0, 1'b0, 0, 3, "t6_code_reverted");
    lk();

    // 6c: async reset mid-lockout
    enter4(16'h0000); clr();
    enter4(16'h0000); clr();
    enter4(16'h0000); chk_both(1'b0, 1'b1, 1'b1, 0, 0, "t6_lockout_entry");
    idle();    chk_both(1'b0, 1'b1, 1'b1, 0, 0, "t6_pre_rst_lockout");
    @(negedge clk);
    @(posedge clk);
    #2;
    reset = 1'b0;
    chk_now_both("t6_async_rst_lockout");
    idle();
    reset = 1'b1;
    enter4(16'h1234); chk_both(1'b1, 1'b0, 1'b0, 0, 3, "t6_open_after_rst");
    lk();
    idle();

    done = 1'b1;
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
